// File: rtl/phys_reg_free_buffer.sv
// Staging FIFO between ROB commit (two free lanes per cycle) and the physical register free list.
// Optional macro PHYS_REG_FREE_BUFFER_ZERO_CHECK_EN flags tag-0 frees as protocol errors.
module phys_reg_free_buffer #(
  parameter  int FREE_BUF_DEPTH = 4,
  parameter  int TAG_W          = 6,
  localparam int IDX_W          = $clog2(FREE_BUF_DEPTH),
  localparam int CNT_W          = IDX_W + 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            commit_free_valid,
  input  logic [1:0][TAG_W-1:0] commit_free_phys_reg_tag,
  output logic                  commit_free_ready,
  input  logic                  free_list_full,
  output logic                  enqueue_valid,
  output logic [TAG_W-1:0]      enqueue_phys_reg_tag,
  output logic [CNT_W-1:0]      buf_count,
  output logic                  DUT_error
);

  logic [TAG_W-1:0] r_mem [FREE_BUF_DEPTH];
  logic [CNT_W-1:0] r_head;
  logic [CNT_W-1:0] r_tail;
  logic             r_error;

  logic [CNT_W-1:0] w_count;
  logic [CNT_W-1:0] w_space;
  logic [CNT_W-1:0] w_tail_l1;
  logic             w_ready;
  logic [1:0]       w_tag_nz;
  logic [1:0]       w_lane_acc;
  logic [1:0]       w_n_acc;
  logic             w_ovf;
  logic             w_wr_en;
  logic             w_drain;
  logic             w_err_next;

  // Occupancy, free space and acceptance decode from registered pointers.
  always_comb begin
    w_count     = r_tail - r_head;
    w_space     = CNT_W'(FREE_BUF_DEPTH) - w_count;
    w_ready     = (w_space >= CNT_W'(2));
    w_tag_nz[0] = (commit_free_phys_reg_tag[0] != TAG_W'(0));
    w_tag_nz[1] = (commit_free_phys_reg_tag[1] != TAG_W'(0));
    w_lane_acc  = commit_free_valid & w_tag_nz & {2{w_ready}};
    w_n_acc     = {1'b0, w_lane_acc[0]} + {1'b0, w_lane_acc[1]};
    w_ovf       = (CNT_W'(w_n_acc) > w_space);
    w_wr_en     = ~RST & ~w_ovf;
    // Lane 1 lands behind lane 0 only when lane 0 actually took a slot.
    w_tail_l1   = r_tail + CNT_W'(w_lane_acc[0]);
  end

  // Drain side and externally visible status; reset forces the idle view.
  always_comb begin
    w_drain              = ~RST & (w_count != CNT_W'(0)) & ~free_list_full;
    enqueue_valid        = w_drain;
    enqueue_phys_reg_tag = r_mem[r_head[IDX_W-1:0]];
    commit_free_ready    = RST | w_ready;
    DUT_error            = r_error & ~RST;
    if (RST) begin
      buf_count = CNT_W'(0);
    end else begin
      buf_count = w_count;
    end
  end

  // Protocol error sources for next cycle's pulse.
  always_comb begin
    w_err_next = ((|commit_free_valid) & ~w_ready) | w_ovf;
`ifdef PHYS_REG_FREE_BUFFER_ZERO_CHECK_EN
    if (w_ready && ((commit_free_valid & ~w_tag_nz) != 2'b00)) begin
      w_err_next = 1'b1;
    end else begin
      w_err_next = w_err_next;
    end
`endif
  end

  // Tag storage; contents are intentionally not cleared by reset.
  always_ff @(posedge CLK) begin
    if (w_wr_en) begin
      if (w_lane_acc[0]) begin
        r_mem[r_tail[IDX_W-1:0]] <= commit_free_phys_reg_tag[0];
      end
      if (w_lane_acc[1]) begin
        r_mem[w_tail_l1[IDX_W-1:0]] <= commit_free_phys_reg_tag[1];
      end
    end
  end

  // Pointer and error-pulse state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_head  <= CNT_W'(0);
      r_tail  <= CNT_W'(0);
      r_error <= 1'b0;
    end else begin
      r_head  <= r_head + CNT_W'(w_drain);
      r_tail  <= w_ovf ? r_tail : (r_tail + CNT_W'(w_n_acc));
      r_error <= w_err_next;
    end
  end

endmodule

// File: doc/phys_reg_free_buffer.md
PHYS_REG_FREE_BUFFER -- requirements
Module: phys_reg_free_buffer

Interface
REQ-001 SHALL have parameter FREE_BUF_DEPTH, default 4, buffer entries; power of two, >= 2.
REQ-002 SHALL have port CLK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port commit_free_valid, input, 2 bits: per-lane request to free a phys reg at ROB commit.
REQ-005 SHALL have port commit_free_phys_reg_tag, input, 2 x phys_reg_tag_t: tag per lane.
REQ-006 SHALL have port commit_free_ready, output, 1 bit: buffer can accept two frees this cycle.
REQ-007 SHALL have port free_list_full, input, 1 bit: full flag from the free list.
REQ-008 SHALL have port enqueue_valid, output, 1 bit: enqueue strobe to the free list.
REQ-009 SHALL have port enqueue_phys_reg_tag, output, phys_reg_tag_t: tag being enqueued.
REQ-010 SHALL have port buf_count, output, log2(FREE_BUF_DEPTH)+1 bits: current occupancy.
REQ-011 SHALL have port DUT_error, output, 1 bit: registered protocol-error pulse.

Function
REQ-012 SHALL hold tags in a circular FIFO with head/tail pointers carrying an extra wrap msb; full/empty derived from index and msb.
REQ-013 SHALL accept a lane when commit_free_valid[i]=1, commit_free_ready=1, and tag != 0; tag 0 SHALL be dropped without occupying a slot.
REQ-014 SHALL write lane 0 before lane 1 when both are accepted; with only lane 1 accepted, it SHALL take the tail slot.
REQ-015 SHALL drive commit_free_ready = 1 iff (FREE_BUF_DEPTH - buf_count) >= 2, from registered state only.
REQ-016 SHALL ignore all lanes when commit_free_valid != 0 and commit_free_ready = 0, and set DUT_error next cycle.
REQ-017 SHALL drive enqueue_valid = (buf_count != 0) & ~free_list_full, combinationally, with enqueue_phys_reg_tag = entry at head.
REQ-018 SHALL advance head by one on every cycle enqueue_valid = 1.
REQ-019 SHALL give a minimum latency of one cycle: a free accepted in cycle N is first visible on enqueue at N+1; no bypass.
REQ-020 SHALL allow write of up to two entries and drain of one entry in the same cycle; buf_count(next) = buf_count + accepted - drained.
REQ-021 SHALL hold the head entry stable while free_list_full = 1 and resume draining the cycle after it drops.
REQ-022 SHALL wrap pointers modulo FREE_BUF_DEPTH with msb toggled on wrap; buf_count = tail - head in (log2+1)-bit arithmetic.
REQ-023 SHALL never overflow: any internal write that would exceed FREE_BUF_DEPTH is suppressed and sets DUT_error.
REQ-024 SHALL pulse DUT_error for one cycle per error cycle (not sticky).

Reset
REQ-025 SHALL, when RST = 1 at a rising edge, clear head, tail, buf_count, and DUT_error to 0 regardless of in-flight requests.
REQ-026 SHALL output, during and after reset, enqueue_valid = 0, commit_free_ready = 1, buf_count = 0, DUT_error = 0.
REQ-027 SHALL discard requests presented in the same cycle RST = 1; buffer contents need not be cleared.

Configuration
REQ-028 SHALL recognize macro PHYS_REG_FREE_BUFFER_ZERO_CHECK_EN.
REQ-029 SHALL, with the macro defined, also set DUT_error on the cycle after any accepted-window lane with commit_free_valid = 1 and tag 0; the tag is still dropped.
REQ-030 SHALL, without the macro, drop tag-0 frees silently; DUT_error is then driven only by REQ-016/REQ-023.

Verification
REQ-031 SHALL cover: after reset, lanes {valid=2'b11, tags 5,9} -> next cycle enqueue 5, then 9; buf_count 2,1,0.
REQ-032 SHALL cover: free_list_full=1 for 3 cycles with buf_count=1 (tag 7) -> enqueue_valid=0 for 3 cycles, tag 7 enqueued on the 4th.
REQ-033 SHALL cover: depth 4, full held high, two dual frees (tags 1-4) -> buf_count=4, commit_free_ready=0; a third request -> ignored, DUT_error=1 next cycle.
REQ-034 SHALL cover: valid=2'b11 with tags {0,12} -> only 12 buffered, buf_count=1; DUT_error=1 only if the macro is defined.
REQ-035 SHALL cover: 10 cycles of single-lane frees (tags 1..10) with concurrent draining -> enqueue order 1..10 across pointer wrap, no DUT_error.
REQ-036 SHALL cover: RST=1 with buf_count=3 -> next cycle buf_count=0, enqueue_valid=0, commit_free_ready=1.
